seq_hit_monitor: RTL and testbench

Windowed statistics stage placed directly downstream of the overlapping Mealy sequence detectors: its `hit` input is driven by a detector's single-cycle match output `z`. It counts matches over fixed windows of `WINDOW` clock cycles. At the end of each window it reports the count, an overflow flag and, optionally, the minimum spacing between matches. It raises a sticky alarm when any completed window meets `THRESH`.

---
 rtl/seq_hit_monitor.sv | 135 +++++++++++++
 tb/tb_seq_hit_monitor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_hit_monitor.sv
// rtl/seq_hit_monitor.sv - windowed match counter with threshold alarm
// Optional minimum-gap tracking is compiled in with `define SEQ_MON_GAP_EN.
module seq_hit_monitor #(
  parameter int WINDOW = 64,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hit,
  input  logic             clr_alarm,
  output logic [CNT_W-1:0] window_count,
  output logic             window_ovf,
  output logic             window_done,
  output logic             alarm,
  output logic [CNT_W-1:0] min_gap
);

  localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WC_W-1:0]  wc;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             run_ovf;
  logic             ovf_next;

  // Count including the current cycle's hit, saturating instead of wrapping.
  always_comb begin
    cnt_next = run_cnt;
    ovf_next = run_ovf;
    if (hit) begin
      if (run_cnt == CNT_MAX) ovf_next = 1'b1;
      else                    cnt_next = run_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wc           <= '0;
      run_cnt      <= '0;
      run_ovf      <= 1'b0;
      window_count <= '0;
      window_ovf   <= 1'b0;
      window_done  <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (clr_alarm) alarm <= 1'b0;
      case (state)
        IDLE: begin
          wc      <= '0;
          run_cnt <= '0;
          run_ovf <= 1'b0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state   <= IDLE;
            wc      <= '0;
            run_cnt <= '0;
            run_ovf <= 1'b0;
          end else if (wc == WC_LAST) begin
            window_count <= cnt_next;
            window_ovf   <= ovf_next;
            window_done  <= 1'b1;
            // Placed after the clear so a coinciding set takes priority.
            if (cnt_next >= THR) alarm <= 1'b1;
            wc      <= '0;
            run_cnt <= '0;
            run_ovf <= 1'b0;
          end else begin
            wc      <= wc + 1'b1;
            run_cnt <= cnt_next;
            run_ovf <= ovf_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_MON_GAP_EN
  logic [WC_W-1:0]  last_wc;
  logic             have_prev;
  logic [CNT_W-1:0] run_gap;
  logic [CNT_W-1:0] gap_next;
  logic [CNT_W-1:0] gap_val;
  logic [31:0]      diff;

  always_comb begin
    diff     = 32'(wc) - 32'(last_wc);
    gap_val  = (diff > 32'(CNT_MAX)) ? CNT_MAX : diff[CNT_W-1:0];
    gap_next = run_gap;
    if (hit && have_prev && (gap_val < run_gap)) gap_next = gap_val;
  end

  // Gap history is wiped at every window boundary and whenever the window aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_wc   <= '0;
      have_prev <= 1'b0;
      run_gap   <= '1;
      min_gap   <= '1;
    end else if (state == RUN && en) begin
      if (wc == WC_LAST) begin
        min_gap   <= gap_next;
        last_wc   <= '0;
        have_prev <= 1'b0;
        run_gap   <= '1;
      end else begin
        run_gap <= gap_next;
        if (hit) begin
          last_wc   <= wc;
          have_prev <= 1'b1;
        end
      end
    end else begin
      last_wc   <= '0;
      have_prev <= 1'b0;
      run_gap   <= '1;
    end
  end
`else
  assign min_gap = '1;
`endif

endmodule

// File: tb/tb_seq_hit_monitor.sv
// tb/tb_seq_hit_monitor.sv - directed self-checking bench for seq_hit_monitor
module tb_seq_hit_monitor;

  logic clk = 1'b0;
  logic rst, en, hit_drv, ser_in, clr_alarm, use_det;
  logic [2:0] sh;
  logic z, hit;

  logic [2:0] window_count, min_gap;
  logic       window_ovf, window_done, alarm;
  logic [1:0] s_window_count, s_min_gap;
  logic       s_window_ovf, s_window_done, s_alarm;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SEQ_MON_GAP_EN
  localparam logic [2:0] GAP_EXP = 3'd3;
`else
  localparam logic [2:0] GAP_EXP = 3'd7;
`endif

  always #5 clk = ~clk;

  // Overlapping Mealy "1011" detector feeding the monitor.
  always @(posedge clk) sh <= {sh[1:0], ser_in};
  assign z   = ser_in & (sh == 3'b101);
  assign hit = use_det ? z : hit_drv;

  seq_hit_monitor #(.WINDOW(8), .CNT_W(3), .THRESH(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .hit(hit), .clr_alarm(clr_alarm),
    .window_count(window_count), .window_ovf(window_ovf),
    .window_done(window_done), .alarm(alarm), .min_gap(min_gap)
  );

  seq_hit_monitor #(.WINDOW(8), .CNT_W(2), .THRESH(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .hit(hit), .clr_alarm(clr_alarm),
    .window_count(s_window_count), .window_ovf(s_window_ovf),
    .window_done(s_window_done), .alarm(s_alarm), .min_gap(s_min_gap)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full window from window cycle 0; m holds hit (or serial) bits per cycle.
  task automatic run_window(input logic [7:0] m, input logic [7:0] clr, input bit det);
    use_det = det;
    for (int i = 0; i < 8; i++) begin
      if (det) begin ser_in = m[i]; hit_drv = 1'b0; end
      else     begin hit_drv = m[i]; ser_in = 1'b0; end
      clr_alarm = clr[i];
      tick();
      if (i < 7) check_eq("done_mid_window", {30'd0, window_done, s_window_done}, 32'd0);
    end
    hit_drv = 1'b0; ser_in = 1'b0; clr_alarm = 1'b0; use_det = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; hit_drv = 1'b0; ser_in = 1'b0; clr_alarm = 1'b0; use_det = 1'b0;

    // Reset with random activity
    for (int i = 0; i < 6; i++) begin
      en = 1'($urandom_range(0, 1));
      hit_drv = 1'($urandom_range(0, 1));
      tick();
      check_eq("rst_done", {31'd0, window_done}, 32'd0);
    end
    check_eq("rst_count", window_count, 3'd0);
    check_eq("rst_ovf",   window_ovf, 1'b0);
    check_eq("rst_alarm", {31'd0, alarm | s_alarm}, 32'd0);
    check_eq("rst_gap",   min_gap, 3'd7);
    check_eq("rst_sgap",  s_min_gap, 2'd3);

    rst = 1'b0; hit_drv = 1'b0; en = 1'b1;
    hit_drv = 1'b1;
    tick();  // enable edge; hit ignored while still idle
    hit_drv = 1'b0;

    // Hits at cycles 0 and 7
    run_window(8'b1000_0001, 8'h00, 1'b0);
    check_eq("t2_count", window_count, 3'd2);
    check_eq("t2_ovf",   window_ovf, 1'b0);
    check_eq("t2_done",  window_done, 1'b1);
    check_eq("t2_alarm", alarm, 1'b1);
    check_eq("t2_gap",   min_gap, GAP_EXP == 3'd3 ? 3'd7 : 3'd7);

    run_window(8'h00, 8'h00, 1'b0);
    check_eq("empty_count", window_count, 3'd0);
    check_eq("empty_done",  window_done, 1'b1);
    check_eq("alarm_sticky", alarm, 1'b1);

    // Abort at window cycle 4
    hit_drv = 1'b1; tick(); tick(); tick();
    hit_drv = 1'b0; tick();
    en = 1'b0; tick();
    check_eq("abort_done",  window_done, 1'b0);
    check_eq("abort_count", window_count, 3'd0);
    hit_drv = 1'b1; tick();
    check_eq("idle_done", window_done, 1'b0);
    en = 1'b1; tick();
    hit_drv = 1'b0;
    run_window(8'b0001_0000, 8'h00, 1'b0);
    check_eq("t3_count", window_count, 3'd1);
    check_eq("t3_done",  window_done, 1'b1);
    tick();
    check_eq("done_one_cycle", window_done, 1'b0);
    en = 1'b0; tick(); en = 1'b1; tick();

    // Saturation
    run_window(8'hFF, 8'h00, 1'b0);
    check_eq("sat_count", window_count, 3'd7);
    check_eq("sat_ovf",   window_ovf, 1'b1);
    check_eq("sat2_count", s_window_count, 2'd3);
    check_eq("sat2_ovf",   s_window_ovf, 1'b1);
    check_eq("sat2_done",  s_window_done, 1'b1);
    run_window(8'h00, 8'h00, 1'b0);
    check_eq("post_sat_count", window_count, 3'd0);
    check_eq("post_sat_ovf",   window_ovf, 1'b0);
    check_eq("post_sat2_count", s_window_count, 2'd0);
    check_eq("post_sat2_ovf",   s_window_ovf, 1'b0);

    // Alarm set and clear coincide: set wins
    run_window(8'h03, 8'h80, 1'b0);
    check_eq("set_wins_count", window_count, 3'd2);
    check_eq("set_wins_alarm", alarm, 1'b1);
    en = 1'b0; clr_alarm = 1'b1; tick();
    clr_alarm = 1'b0;
    check_eq("clr_alarm", alarm, 1'b0);
    en = 1'b1; tick();

    // Single hit: below threshold, no gap
    run_window(8'h10, 8'h00, 1'b0);
    check_eq("single_count", window_count, 3'd1);
    check_eq("single_alarm", alarm, 1'b0);
    check_eq("single_gap",   min_gap, 3'd7);
    check_eq("single_sgap",  s_min_gap, 2'd3);

    // Detector-driven hits at cycles 3 and 6 from serial 1011011
    run_window(8'b0110_1101, 8'h00, 1'b1);
    check_eq("det_count", window_count, 3'd2);
    check_eq("det_gap",   min_gap, GAP_EXP);
    check_eq("det_alarm", alarm, 1'b1);

    // Reset mid-window
    hit_drv = 1'b1; tick(); tick(); tick();
    rst = 1'b1; tick();
    check_eq("midrst_done",  window_done, 1'b0);
    check_eq("midrst_count", window_count, 3'd0);
    check_eq("midrst_alarm", alarm, 1'b0);
    rst = 1'b0; hit_drv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("after_rst_done", window_done, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
